// File: rtl/ram_loader_pkg.sv
// Shared widths and FSM state encoding for the nibble RAM loader.
// The design files and the bench both import this package.
package ram_loader_pkg;

  localparam int ADDR_W = 12;
  localparam int DATA_W = 4;

  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    FILL_WAIT   = 3'd1,
    FILL_SETUP  = 3'd2,
    FILL_WRITE  = 3'd3,
    DUMP_ADDR   = 3'd4,
    DUMP_SAMPLE = 3'd5,
    DUMP_OUT    = 3'd6,
    DONE        = 3'd7
  } state_t;

endpackage

// File: rtl/ram_addr_counter.sv
// Current RAM address and remaining nibble count for one transfer.
// It loads base and length, then advances once per completed nibble.
module ram_addr_counter #(
  parameter int ADDR_W = ram_loader_pkg::ADDR_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              load,
  input  logic              advance,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [ADDR_W-1:0] load_length,
  output logic [ADDR_W-1:0] addr,
  output logic              last,
  output logic              zero
);

  // One extra bit is needed so that a length of 0 can stand for a full sweep.
  logic [ADDR_W:0] remaining;

  always_ff @(posedge clock) begin
    if (reset) begin
      addr      <= '0;
      remaining <= '0;
    end else if (load) begin
      addr      <= load_addr;
      remaining <= (load_length == '0) ? {1'b1, {ADDR_W{1'b0}}}
                                       : {1'b0, load_length};
    end else if (advance && !zero) begin
      addr      <= addr + 1'b1;
      remaining <= remaining - 1'b1;
    end
  end

  assign last = (remaining == {{ADDR_W{1'b0}}, 1'b1});
  assign zero = (remaining == '0);

endmodule

// File: rtl/ram_loader.sv
// Moves nibbles between a valid/ready stream and an external RAM bus.
// Fill streams into RAM, dump streams RAM contents out.
module ram_loader
  import ram_loader_pkg::*;
#(
  parameter int ADDR_W = ram_loader_pkg::ADDR_W,
  parameter int DATA_W = ram_loader_pkg::DATA_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              mode,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] length,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] address_RAM,
  output logic              csRAM,
  output logic              weRAM,
  inout  wire  [DATA_W-1:0] data
);

  state_t state;
  state_t state_next;

  logic [DATA_W-1:0] wr_data;
  logic              drive;
  logic              load;
  logic              advance;
  logic              last;
  logic              zero;

  ram_addr_counter #(
    .ADDR_W(ADDR_W)
  ) u_counter (
    .clock      (clock),
    .reset      (reset),
    .load       (load),
    .advance    (advance),
    .load_addr  (base_addr),
    .load_length(length),
    .addr       (address_RAM),
    .last       (last),
    .zero       (zero)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_data  <= '0;
      out_data <= '0;
    end else begin
      if (state == FILL_WAIT && in_valid) begin
        wr_data <= in_data;
      end
      if (state == DUMP_SAMPLE) begin
        out_data <= data;
      end
    end
  end

  // The loader owns the data bus only while the write strobe is up.
  assign data = drive ? wr_data : {DATA_W{1'bz}};

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    csRAM      = 1'b0;
    weRAM      = 1'b0;
    drive      = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    load       = 1'b0;
    advance    = 1'b0;

    case (state)
      IDLE: begin
        if (start) begin
          load       = 1'b1;
          state_next = mode ? DUMP_ADDR : FILL_WAIT;
        end
      end
      FILL_WAIT: begin
        busy     = 1'b1;
        in_ready = 1'b1;
        if (in_valid) begin
          state_next = FILL_SETUP;
        end
      end
      FILL_SETUP: begin
        busy       = 1'b1;
        csRAM      = 1'b1;
        state_next = FILL_WRITE;
      end
      FILL_WRITE: begin
        busy       = 1'b1;
        csRAM      = 1'b1;
        weRAM      = 1'b1;
        drive      = 1'b1;
        advance    = 1'b1;
        state_next = (last || zero) ? DONE : FILL_WAIT;
      end
      DUMP_ADDR: begin
        busy       = 1'b1;
        csRAM      = 1'b1;
        state_next = DUMP_SAMPLE;
      end
      DUMP_SAMPLE: begin
        busy       = 1'b1;
        csRAM      = 1'b1;
        state_next = DUMP_OUT;
      end
      DUMP_OUT: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) begin
          advance    = 1'b1;
          state_next = (last || zero) ? DONE : DUMP_ADDR;
        end
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_ram_loader.sv
// Self-checking bench for ram_loader: a behavioural RAM on the bus, a
// reference memory image, and randomized fill/dump transfers.
module tb_ram_loader;
  import ram_loader_pkg::*;

  localparam int AW    = ADDR_W;
  localparam int DW    = DATA_W;
  localparam int DEPTH = 1 << AW;

  logic          clock = 1'b0;
  logic          reset;
  logic          start;
  logic          mode;
  logic [AW-1:0] base_addr;
  logic [AW-1:0] length;
  logic [DW-1:0] in_data;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;
  logic          busy;
  logic          done;
  logic [AW-1:0] address_RAM;
  logic          csRAM;
  logic          weRAM;
  wire  [DW-1:0] data;

  logic [DW-1:0] mem     [DEPTH];
  logic [DW-1:0] ref_mem [DEPTH];
  logic [DW-1:0] fill_q  [$];
  logic          ram_init;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always #5 clock = ~clock;

  ram_loader dut (
    .clock      (clock),
    .reset      (reset),
    .start      (start),
    .mode       (mode),
    .base_addr  (base_addr),
    .length     (length),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .busy       (busy),
    .done       (done),
    .address_RAM(address_RAM),
    .csRAM      (csRAM),
    .weRAM      (weRAM),
    .data       (data)
  );

  // Asynchronous-read, synchronous-write RAM on the initiator bus.
  assign data = (csRAM && !weRAM) ? mem[address_RAM] : {DW{1'bz}};

  always @(posedge clock) begin
    cyc <= cyc + 1;
    if (ram_init) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= ref_mem[i];
    end else if (csRAM && weRAM) begin
      mem[address_RAM] <= data;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Bus rules watched on every cycle.
  logic          prev_cs = 1'b0;
  logic [AW-1:0] prev_addr = '0;
  always @(negedge clock) begin
    checkOutput("we_without_cs", 32'(weRAM && !csRAM), 32'd0);
    if (prev_cs && csRAM) checkOutput("addr_stable", 32'(address_RAM), 32'(prev_addr));
    prev_cs   <= csRAM;
    prev_addr <= address_RAM;
  end

  task automatic applyStimulus(input logic m, input logic [AW-1:0] b, input int n,
                               output int t0);
    logic [31:0] n_bits;
    n_bits    = 32'(n);
    start     = 1'b1;
    mode      = m;
    base_addr = b;
    length    = n_bits[AW-1:0];
    @(negedge clock);
    start = 1'b0;
    checkOutput("busy_after_start", 32'(busy), 32'd1);
    t0 = cyc;
  endtask

  task automatic wait_done(input int t0, input int n, input bit timed, output int extra);
    int guard;
    guard = 0;
    extra = 0;
    while (!done && guard < 50) begin
      if (out_valid && out_ready) extra++;
      @(negedge clock);
      guard++;
    end
    checkOutput("done_seen", 32'(done), 32'd1);
    checkOutput("busy_at_done", 32'(busy), 32'd0);
    if (timed) checkOutput("latency", 32'(cyc - t0), 32'(3 * n));
    @(negedge clock);
    checkOutput("done_one_cycle", 32'(done), 32'd0);
    checkOutput("busy_after_done", 32'(busy), 32'd0);
  endtask

  task automatic compare_mem(input string tag);
    int mism;
    mism = 0;
    for (int i = 0; i < DEPTH; i++) if (mem[i] !== ref_mem[i]) mism++;
    checkOutput(tag, 32'(mism), 32'd0);
  endtask

  task automatic run_fill(input logic [AW-1:0] b, input int stall, input bit pulse_start);
    int n, idx, guard, t0, extra;
    bit pulsed;
    n      = fill_q.size();
    pulsed = 1'b0;
    applyStimulus(1'b0, b, n, t0);
    idx   = 0;
    guard = 0;
    while (idx < n && guard < 8 * n + 100) begin
      if (pulse_start && idx == 1 && !pulsed) begin
        start     = 1'b1;
        mode      = 1'b1;
        base_addr = b + 12'h100;
        length    = 12'd1;
        pulsed    = 1'b1;
      end else begin
        start = 1'b0;
      end
      in_valid = ($urandom_range(0, 99) >= stall);
      in_data  = fill_q[idx];
      if (in_valid && in_ready) idx++;
      @(negedge clock);
      guard++;
    end
    in_valid = 1'b0;
    start    = 1'b0;
    checkOutput("fill_accepted", 32'(idx), 32'(n));
    wait_done(t0, n, stall == 0, extra);
    for (int i = 0; i < n; i++) begin
      logic [AW-1:0] a;
      a = b + AW'(i);
      ref_mem[a] = fill_q[i];
    end
    compare_mem("fill_mem_image");
  endtask

  task automatic run_dump(input logic [AW-1:0] b, input int n, input int stall,
                          input bit hold5);
    logic [DW-1:0] expv [$];
    logic [DW-1:0] prev_data;
    bit            prev_stall;
    int            idx, guard, t0, hold, extra;
    for (int i = 0; i < n; i++) begin
      logic [AW-1:0] a;
      a = b + AW'(i);
      expv.push_back(ref_mem[a]);
    end
    applyStimulus(1'b1, b, n, t0);
    idx        = 0;
    guard      = 0;
    hold       = 0;
    prev_stall = 1'b0;
    prev_data  = '0;
    while (idx < n && guard < 8 * n + 100) begin
      if (hold5 && idx == 0 && out_valid && hold < 5) begin
        out_ready = 1'b0;
        hold++;
      end else begin
        out_ready = ($urandom_range(0, 99) >= stall);
      end
      if (prev_stall) begin
        checkOutput("stall_valid", 32'(out_valid), 32'd1);
        checkOutput("stall_data", 32'(out_data), 32'(prev_data));
      end
      if (out_valid) checkOutput("cs_low_in_out", 32'(csRAM), 32'd0);
      if (out_valid && out_ready) begin
        checkOutput("dump_data", 32'(out_data), 32'(expv[idx]));
        idx++;
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      @(negedge clock);
      guard++;
    end
    out_ready = 1'b1;
    wait_done(t0, n, (stall == 0) && !hold5, extra);
    checkOutput("dump_handshakes", 32'(idx + extra), 32'(n));
    compare_mem("dump_mem_image");
  endtask

  initial begin
    int            t0, guard, n;
    logic [AW-1:0] b;
    logic [DW-1:0] nib;

    reset     = 1'b1;
    ram_init  = 1'b1;
    start     = 1'b0;
    mode      = 1'b0;
    base_addr = '0;
    length    = '0;
    in_data   = '0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = DW'($urandom);

    repeat (3) @(negedge clock);
    ram_init = 1'b0;
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_done", 32'(done), 32'd0);
    checkOutput("rst_cs", 32'(csRAM), 32'd0);
    checkOutput("rst_we", 32'(weRAM), 32'd0);
    checkOutput("rst_in_ready", 32'(in_ready), 32'd0);
    checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_addr", 32'(address_RAM), 32'd0);
    checkOutput("rst_out_data", 32'(out_data), 32'd0);
    reset = 1'b0;
    @(negedge clock);
    compare_mem("init_mem_image");

    $display("[TB] directed fill/dump at 0x010");
    fill_q = {4'hA, 4'h5, 4'hF};
    run_fill(12'h010, 0, 1'b0);
    checkOutput("ram_010", 32'(mem[12'h010]), 32'hA);
    checkOutput("ram_011", 32'(mem[12'h011]), 32'h5);
    checkOutput("ram_012", 32'(mem[12'h012]), 32'hF);
    run_dump(12'h010, 3, 0, 1'b0);

    $display("[TB] wrap fill at 0xFFE");
    fill_q = {};
    for (int i = 0; i < 3; i++) fill_q.push_back(DW'($urandom));
    run_fill(12'hFFE, 0, 1'b0);
    checkOutput("ram_001_untouched", 32'(mem[12'h001]), 32'(ref_mem[12'h001]));
    checkOutput("ram_000_written", 32'(mem[12'h000]), 32'(fill_q[2]));

    $display("[TB] dump with 5-cycle out_ready stall");
    run_dump(12'hFFE, 3, 0, 1'b1);

    $display("[TB] reset during write");
    b   = AW'($urandom);
    nib = ref_mem[b];
    applyStimulus(1'b0, b, 4, t0);
    in_valid = 1'b1;
    in_data  = nib;
    guard    = 0;
    while (!weRAM && guard < 20) begin
      @(negedge clock);
      guard++;
    end
    checkOutput("reached_write", 32'(weRAM), 32'd1);
    in_valid = 1'b0;
    reset    = 1'b1;
    @(negedge clock);
    checkOutput("mid_rst_cs", 32'(csRAM), 32'd0);
    checkOutput("mid_rst_we", 32'(weRAM), 32'd0);
    checkOutput("mid_rst_busy", 32'(busy), 32'd0);
    checkOutput("mid_rst_done", 32'(done), 32'd0);
    checkOutput("mid_rst_in_ready", 32'(in_ready), 32'd0);
    checkOutput("mid_rst_addr", 32'(address_RAM), 32'd0);
    checkOutput("mid_rst_out_data", 32'(out_data), 32'd0);
    reset = 1'b0;
    repeat (2) @(negedge clock);
    checkOutput("no_resume", 32'(busy), 32'd0);
    compare_mem("mem_after_reset");

    $display("[TB] randomized transfers");
    for (int k = 0; k < 12; k++) begin
      b = AW'($urandom);
      n = $urandom_range(1, 10);
      if ($urandom_range(0, 1) == 0) begin
        fill_q = {};
        for (int i = 0; i < n; i++) fill_q.push_back(DW'($urandom));
        run_fill(b, $urandom_range(0, 60), 1'b0);
      end else begin
        run_dump(b, n, $urandom_range(0, 60), 1'b0);
      end
    end

    $display("[TB] start while busy");
    fill_q = {};
    for (int i = 0; i < 4; i++) fill_q.push_back(DW'($urandom));
    run_fill(AW'($urandom), 0, 1'b1);
    repeat (3) @(negedge clock);
    checkOutput("no_second_transfer", 32'(busy), 32'd0);

    $display("[TB] length 0 fill of full RAM");
    fill_q = {};
    for (int i = 0; i < DEPTH; i++) fill_q.push_back(DW'($urandom));
    run_fill(AW'($urandom), 0, 1'b0);
    run_dump(AW'($urandom), 6, 20, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
